// File: rtl/bounce_if.sv
`default_nettype none
// ============================================================================
// bounce_if : frame/pause inputs and sprite origin/colour outputs of
//             bounce_controller.                              Rev 1.0
// ============================================================================
interface bounce_if;
  logic [31:0] frame;
  logic        pause;
  logic [9:0]  sprite_x;
  logic [8:0]  sprite_y;
  logic [2:0]  color_idx;
  logic        bounce_x;
  logic        bounce_y;
  logic        corner_hit;
  logic [15:0] hit_count;

  modport master (
    output frame, pause,
    input  sprite_x, sprite_y, color_idx, bounce_x, bounce_y, corner_hit, hit_count
  );

  modport slave (
    input  frame, pause,
    output sprite_x, sprite_y, color_idx, bounce_x, bounce_y, corner_hit, hit_count
  );
endinterface
`default_nettype wire

// File: rtl/bounce_controller.sv
`default_nettype none
// ============================================================================
// bounce_controller : per-frame sprite motion scheduler with edge clamping,
//                     direction flip, palette stepping and corner counting.
// Rev 1.0
// ============================================================================
module bounce_controller #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int SPRITE_W     = 64,
  parameter int SPRITE_H     = 32,
  parameter int SPEED_X      = 1,
  parameter int SPEED_Y      = 1,
  parameter int PALETTE_SIZE = 8
) (
  input  wire logic clk_25_175,
  input  wire logic rst,
  bounce_if.slave   bus
);

  localparam logic [10:0] c_X_MAX    = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] c_Y_MAX    = 11'(SCREEN_H - SPRITE_H);
  localparam logic [10:0] c_SPEED_X  = 11'(SPEED_X);
  localparam logic [10:0] c_SPEED_Y  = 11'(SPEED_Y);
  localparam logic [2:0]  c_PAL_LAST = 3'(PALETTE_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE_X = 2'd1,
    S_MOVE_Y = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_frame_q;
  logic        r_pending;
  logic [9:0]  r_sprite_x;
  logic [8:0]  r_sprite_y;
  logic        r_dir_x_neg;
  logic        r_dir_y_neg;
  logic [9:0]  r_nx;
  logic [8:0]  r_ny;
  logic        r_flip_x;
  logic        r_flip_y;
  logic [2:0]  r_color_idx;
  logic        r_bounce_x;
  logic        r_bounce_y;
  logic        r_corner_hit;
  logic [15:0] r_hit_count;

  logic [10:0] w_tx;
  logic [10:0] w_ty;
  logic [9:0]  w_nx;
  logic [8:0]  w_ny;
  logic        w_flip_x;
  logic        w_flip_y;
  logic        w_frame_chg;

  assign w_frame_chg = (bus.frame != r_frame_q);
  assign w_tx        = {1'b0, r_sprite_x} + c_SPEED_X;
  assign w_ty        = {2'b00, r_sprite_y} + c_SPEED_Y;

  // 11-bit arithmetic keeps the sum from wrapping before the edge compare.
  always_comb begin
    w_nx     = r_sprite_x;
    w_flip_x = 1'b0;
    if (!r_dir_x_neg) begin
      if (w_tx >= c_X_MAX) begin
        w_nx     = c_X_MAX[9:0];
        w_flip_x = 1'b1;
      end else begin
        w_nx = w_tx[9:0];
      end
    end else if ({1'b0, r_sprite_x} <= c_SPEED_X) begin
      w_nx     = 10'd0;
      w_flip_x = 1'b1;
    end else begin
      w_nx = r_sprite_x - c_SPEED_X[9:0];
    end
  end

  always_comb begin
    w_ny     = r_sprite_y;
    w_flip_y = 1'b0;
    if (!r_dir_y_neg) begin
      if (w_ty >= c_Y_MAX) begin
        w_ny     = c_Y_MAX[8:0];
        w_flip_y = 1'b1;
      end else begin
        w_ny = w_ty[8:0];
      end
    end else if ({2'b00, r_sprite_y} <= c_SPEED_Y) begin
      w_ny     = 9'd0;
      w_flip_y = 1'b1;
    end else begin
      w_ny = r_sprite_y - c_SPEED_Y[8:0];
    end
  end

  always_ff @(posedge clk_25_175 or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_frame_q    <= 32'd0;
      r_pending    <= 1'b0;
      r_sprite_x   <= 10'd0;
      r_sprite_y   <= 9'd0;
      r_dir_x_neg  <= 1'b0;
      r_dir_y_neg  <= 1'b0;
      r_nx         <= 10'd0;
      r_ny         <= 9'd0;
      r_flip_x     <= 1'b0;
      r_flip_y     <= 1'b0;
      r_color_idx  <= 3'd0;
      r_bounce_x   <= 1'b0;
      r_bounce_y   <= 1'b0;
      r_corner_hit <= 1'b0;
      r_hit_count  <= 16'd0;
    end else begin
      r_bounce_x   <= 1'b0;
      r_bounce_y   <= 1'b0;
      r_corner_hit <= 1'b0;

      // A new frame always wins over the IDLE clear, so one change can queue.
      if (w_frame_chg) begin
        r_frame_q <= bus.frame;
        r_pending <= 1'b1;
      end else if (r_state == S_IDLE) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pending && !bus.pause) begin
            r_state <= S_MOVE_X;
          end
        end
        S_MOVE_X: begin
          r_nx     <= w_nx;
          r_flip_x <= w_flip_x;
          r_state  <= S_MOVE_Y;
        end
        S_MOVE_Y: begin
          r_ny     <= w_ny;
          r_flip_y <= w_flip_y;
          r_state  <= S_COMMIT;
        end
        S_COMMIT: begin
          r_sprite_x <= r_nx;
          r_sprite_y <= r_ny;
          r_bounce_x <= r_flip_x;
          r_bounce_y <= r_flip_y;
          if (r_flip_x) begin
            r_dir_x_neg <= ~r_dir_x_neg;
          end
          if (r_flip_y) begin
            r_dir_y_neg <= ~r_dir_y_neg;
          end
          if (r_flip_x || r_flip_y) begin
            r_color_idx <= (r_color_idx >= c_PAL_LAST) ? 3'd0 : r_color_idx + 3'd1;
          end
          if (r_flip_x && r_flip_y) begin
            r_corner_hit <= 1'b1;
            if (r_hit_count != 16'hFFFF) begin
              r_hit_count <= r_hit_count + 16'd1;
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sprite_x   = r_sprite_x;
  assign bus.sprite_y   = r_sprite_y;
  assign bus.color_idx  = r_color_idx;
  assign bus.bounce_x   = r_bounce_x;
  assign bus.bounce_y   = r_bounce_y;
  assign bus.corner_hit = r_corner_hit;
  assign bus.hit_count  = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_bounce_controller.sv
`default_nettype none
// ============================================================================
// tb_bounce_controller : directed bench over three parameterisations sharing
//                        one frame/pause stimulus.                  Rev 1.0
// ============================================================================
module tb_bounce_controller;

  logic        clk;
  logic        rst;
  logic [31:0] frame;
  logic        pause;
  int          checks;
  int          errors;

  bounce_if if_a ();
  bounce_if if_b ();
  bounce_if if_c ();

  assign if_a.frame = frame;
  assign if_a.pause = pause;
  assign if_b.frame = frame;
  assign if_b.pause = pause;
  assign if_c.frame = frame;
  assign if_c.pause = pause;

  bounce_controller u_dut_a (
    .clk_25_175 (clk),
    .rst        (rst),
    .bus        (if_a)
  );

  bounce_controller #(
    .SCREEN_W (100),
    .SCREEN_H (100),
    .SPRITE_W (20),
    .SPRITE_H (20)
  ) u_dut_b (
    .clk_25_175 (clk),
    .rst        (rst),
    .bus        (if_b)
  );

  bounce_controller #(
    .SPEED_X (7)
  ) u_dut_c (
    .clk_25_175 (clk),
    .rst        (rst),
    .bus        (if_c)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each frame change is followed by five falling edges: the commit lands on
  // the fifth rising edge, so the pulses are still visible here.
  task automatic step();
    @(negedge clk);
    frame = frame + 32'd1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    frame  = 32'd0;
    pause  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(if_a.sprite_x), 0);
    chk("rst_y", 32'(if_a.sprite_y), 0);
    chk("rst_color", 32'(if_a.color_idx), 0);
    chk("rst_hits", 32'(if_a.hit_count), 0);
    chk("rst_pulses", 32'({if_a.bounce_x, if_a.bounce_y, if_a.corner_hit}), 0);

    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_move", 32'(if_a.sprite_x), 0);

    @(negedge clk);
    frame = 32'd1;
    repeat (4) @(negedge clk);
    chk("latency_not_yet", 32'(if_a.sprite_x), 0);
    @(negedge clk);
    chk("f1_x", 32'(if_a.sprite_x), 1);
    chk("f1_y", 32'(if_a.sprite_y), 1);
    chk("f1_pulses", 32'({if_a.bounce_x, if_a.bounce_y, if_a.corner_hit}), 0);
    chk("f1_color", 32'(if_a.color_idx), 0);

    for (int f = 2; f <= 577; f++) begin
      step();
      if (f == 80) begin
        chk("b80_x", 32'(if_b.sprite_x), 80);
        chk("b80_y", 32'(if_b.sprite_y), 80);
        chk("b80_pulses", 32'({if_b.bounce_x, if_b.bounce_y, if_b.corner_hit}), 3'b111);
        chk("b80_color", 32'(if_b.color_idx), 1);
        chk("b80_hits", 32'(if_b.hit_count), 1);
      end
      if (f == 82) chk("c82_x", 32'(if_c.sprite_x), 574);
      if (f == 83) begin
        chk("c83_x", 32'(if_c.sprite_x), 576);
        chk("c83_bx", 32'(if_c.bounce_x), 1);
      end
      if (f == 84) begin
        chk("c84_x", 32'(if_c.sprite_x), 569);
        chk("c84_bx", 32'(if_c.bounce_x), 0);
      end
      if (f == 160) begin
        chk("b160_x", 32'(if_b.sprite_x), 0);
        chk("b160_corner", 32'(if_b.corner_hit), 1);
        chk("b160_hits", 32'(if_b.hit_count), 2);
      end
      if (f == 448) begin
        chk("a448_y", 32'(if_a.sprite_y), 448);
        chk("a448_by", 32'(if_a.bounce_y), 1);
        chk("a448_bx", 32'(if_a.bounce_x), 0);
        chk("a448_color", 32'(if_a.color_idx), 1);
      end
      if (f == 575) begin
        chk("a575_x", 32'(if_a.sprite_x), 575);
        chk("a575_bx", 32'(if_a.bounce_x), 0);
      end
      if (f == 576) begin
        chk("a576_x", 32'(if_a.sprite_x), 576);
        chk("a576_bx", 32'(if_a.bounce_x), 1);
        chk("a576_corner", 32'(if_a.corner_hit), 0);
        chk("a576_color", 32'(if_a.color_idx), 2);
      end
      if (f == 577) begin
        chk("a577_x", 32'(if_a.sprite_x), 575);
        chk("a577_y", 32'(if_a.sprite_y), 319);
        chk("b577_x", 32'(if_b.sprite_x), 63);
        chk("b577_hits", 32'(if_b.hit_count), 7);
        chk("b577_color", 32'(if_b.color_idx), 7);
      end
    end

    pause = 1'b1;
    repeat (10) step();
    chk("pause_x", 32'(if_a.sprite_x), 575);
    chk("pause_y", 32'(if_a.sprite_y), 319);
    chk("pause_color", 32'(if_a.color_idx), 2);
    pause = 1'b0;
    step();
    chk("unpause_x", 32'(if_a.sprite_x), 574);
    chk("unpause_y", 32'(if_a.sprite_y), 318);
    repeat (12) @(negedge clk);
    chk("no_backlog_x", 32'(if_a.sprite_x), 574);

    // Second frame change lands while the first update is in MOVE_Y.
    @(negedge clk);
    frame = frame + 32'd1;
    repeat (3) @(negedge clk);
    frame = frame + 32'd1;
    repeat (2) @(negedge clk);
    chk("q1_x", 32'(if_a.sprite_x), 573);
    repeat (3) @(negedge clk);
    chk("q_hold_x", 32'(if_a.sprite_x), 573);
    @(negedge clk);
    chk("q2_x", 32'(if_a.sprite_x), 572);
    chk("q2_y", 32'(if_a.sprite_y), 316);

    @(negedge clk);
    frame = frame + 32'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_x", 32'(if_a.sprite_x), 0);
    chk("abort_y", 32'(if_a.sprite_y), 0);
    chk("abort_color", 32'(if_a.color_idx), 0);
    chk("abort_b_hits", 32'(if_b.hit_count), 0);
    @(negedge clk);
    chk("abort_pulses", 32'({if_a.bounce_x, if_a.bounce_y, if_a.corner_hit}), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_x", 32'(if_a.sprite_x), 1);
    chk("post_rst_y", 32'(if_a.sprite_y), 1);
    chk("post_rst_bx", 32'(if_a.bounce_x), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
